// File: rtl/hamming_secded_decoder.sv
// rtl/hamming_secded_decoder.sv - two-stage SECDED (12,8) decoder with error counters
module hamming_secded_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_err_single,
    output logic        out_err_uncorr,
    output logic [3:0]  out_syndrome,
    input  logic        cnt_clr,
    output logic [15:0] cnt_corr,
    output logic [15:0] cnt_uncorr
);

    logic       s1_valid;
    logic [7:0] s1_data;
    logic [3:0] s1_syn;
    logic [3:0] syn_in;
    logic       load2;
    logic       in_fire;
    logic       out_fire;
    logic [7:0] data_flip;
    logic       mapped;
    logic       uncorr;

    // Syndrome of the incoming word; each term is one parity-check row.
    assign syn_in[3] = ^{in_code[11], in_code[10], in_code[9], in_code[8], in_code[7]};
    assign syn_in[2] = ^{in_code[11], in_code[6], in_code[5], in_code[4], in_code[3]};
    assign syn_in[1] = ^{in_code[10], in_code[9], in_code[6], in_code[5], in_code[2], in_code[1]};
    assign syn_in[0] = ^{in_code[10], in_code[8], in_code[6], in_code[4], in_code[2], in_code[0]};

    assign load2    = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || load2;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Stage 1: capture the data bits and syndrome; parity bits only matter through the syndrome.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= 8'h00;
            s1_syn   <= 4'h0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= {in_code[11:8], in_code[6:4], in_code[2]};
            s1_syn   <= syn_in;
        end else if (load2) begin
            s1_valid <= 1'b0;
        end
    end

    // Map syndrome to the data bit to flip; parity-bit hits are flagged but flip no data.
    always_comb begin
        data_flip = 8'h00;
        mapped    = 1'b1;
        uncorr    = 1'b0;
        case (s1_syn)
            4'b1100: data_flip = 8'h80;
            4'b1011: data_flip = 8'h40;
            4'b1010: data_flip = 8'h20;
            4'b1001: data_flip = 8'h10;
            4'b0111: data_flip = 8'h08;
            4'b0110: data_flip = 8'h04;
            4'b0101: data_flip = 8'h02;
            4'b0011: data_flip = 8'h01;
            4'b1000, 4'b0100, 4'b0010, 4'b0001: data_flip = 8'h00;
            4'b0000: mapped = 1'b0;
            default: begin
                mapped = 1'b0;
                uncorr = 1'b1;
            end
        endcase
    end

    // Stage 2: register the corrected result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_data       <= 8'h00;
            out_err_single <= 1'b0;
            out_err_uncorr <= 1'b0;
            out_syndrome   <= 4'h0;
        end else if (load2) begin
            out_valid      <= 1'b1;
            out_data       <= s1_data ^ data_flip;
            out_err_single <= mapped;
            out_err_uncorr <= uncorr;
            out_syndrome   <= s1_syn;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

    // Saturating event counters, advanced only when a result is consumed; clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_corr   <= 16'h0000;
            cnt_uncorr <= 16'h0000;
        end else if (out_fire) begin
            if (out_err_single && cnt_corr != 16'hFFFF)
                cnt_corr <= cnt_corr + 16'h0001;
            if (out_err_uncorr && cnt_uncorr != 16'hFFFF)
                cnt_uncorr <= cnt_uncorr + 16'h0001;
        end
    end

endmodule

// File: doc/hamming_secded_decoder.md
HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL have no parameters; all widths are fixed (12-bit code, 8-bit data, 4-bit syndrome, 16-bit counters).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  in_code is valid this cycle
- in_ready  out  1  decoder can accept in_code this cycle
- in_code  in  12  received codeword
- out_valid  out  1  decoded result is valid
- out_ready  in  1  downstream accepts the result
- out_data  out  8  decoded (corrected) data
- out_err_single  out  1  single-bit error detected and corrected
- out_err_uncorr  out  1  uncorrectable syndrome detected
- out_syndrome  out  4  syndrome {s3,s2,s1,s0}
- cnt_clr  in  1  synchronous clear of both counters
- cnt_corr  out  16  corrected-word count
- cnt_uncorr  out  16  uncorrectable-word count

Function
REQ-004 Codeword layout SHALL be: code[11:8]=d[7:4], code[7]=p3, code[6:4]=d[3:1], code[3]=p2, code[2]=d[0], code[1]=p1, code[0]=p0.
REQ-005 Syndrome terms SHALL be (^ is XOR):
- s3 = c11^c10^c9^c8^c7
- s2 = c11^c6^c5^c4^c3
- s1 = c10^c9^c6^c5^c2^c1
- s0 = c10^c8^c6^c4^c2^c0
REQ-006 Syndrome-to-bit map SHALL be (syndrome shown as s3s2s1s0):
- 1100->c11, 1011->c10, 1010->c9, 1001->c8
- 0111->c6, 0110->c5, 0101->c4, 0011->c2
- 1000->c7, 0100->c3, 0010->c1, 0001->c0
REQ-007 For syndrome 0000, the decoder SHALL flag no error and pass the data bits through unchanged.
REQ-008 For a mapped syndrome, the decoder SHALL invert the indicated bit, set err_single=1, and set err_uncorr=0; a parity-bit hit SHALL leave the data bits unchanged.
REQ-009 For syndromes 1101, 1110 and 1111, the decoder SHALL set err_uncorr=1 and err_single=0, and out_data SHALL carry the raw data bits, uncorrected.
REQ-010 The decoder SHALL be a 2-stage pipeline:
- stage 1 registers in_code and its syndrome
- stage 2 registers the corrected data, flags and syndrome
- latency is 2 cycles from input handshake to out_valid when no backpressure is applied
REQ-011 An input handshake SHALL occur when in_valid && in_ready; an output handshake SHALL occur when out_valid && out_ready.
REQ-012 Stage 2 SHALL load when stage 1 is valid and (!out_valid || out_ready).
REQ-013 in_ready SHALL equal !s1_valid || stage-2 load condition; this SHALL give full throughput of 1 word per cycle with out_ready held high.
REQ-014 While out_valid=1 and out_ready=0, out_data, the flags and out_syndrome SHALL hold stable.
REQ-015 With backpressure, the pipeline SHALL hold at most 2 words; no word is dropped or duplicated.
REQ-016 Counters SHALL update only on an output handshake:
- cnt_corr increments when err_single=1
- cnt_uncorr increments when err_uncorr=1
REQ-017 Each counter SHALL saturate at 0xFFFF and not wrap.
REQ-018 cnt_clr SHALL zero both counters and SHALL take priority over a same-cycle increment.
REQ-019 out_data, the flags and out_syndrome SHALL be registered outputs with no combinational path from in_code.

Reset
REQ-020 When rst_n=0 at a clock edge, the block SHALL:
- clear s1_valid and out_valid
- zero out_data, out_err_single, out_err_uncorr, out_syndrome, cnt_corr and cnt_uncorr
- drive in_ready=1 from the following cycle
REQ-021 A reset asserted mid-operation SHALL discard all in-flight words; no output handshake occurs for them after reset deasserts.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Clean word: in_code=0xA27 -> 2 cycles later out_data=0xA5, syndrome=0000, both flags 0, counters unchanged.
- Data-bit error: in_code=0xE27 (c10 flipped) -> out_data=0xA5, syndrome=1011, err_single=1; cnt_corr increments by 1 on the handshake.
- Parity-bit error: in_code=0xAA7 (c7 flipped) -> out_data=0xA5, syndrome=1000, err_single=1.
- Uncorrectable: in_code=0x226 (c11 and c0 flipped) -> syndrome=1101, err_uncorr=1, out_data=0x25; cnt_uncorr increments.
- Backpressure: stream 4 words with out_ready=0 for 5 cycles -> in_ready falls after 2 words are accepted; all 4 emerge in order with no loss.
- Counter limits: preload cnt_corr to 0xFFFF via a long run, then one more correctable word -> count stays 0xFFFF. cnt_clr together with a correctable handshake in the same cycle -> count = 0.
